// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path: default sizes,
// requester slot assignments and a small pointer helper.
package regfile_pkg;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DEPTH      = 2;

   localparam int REQ_ALU  = 0;
   localparam int REQ_LOAD = 1;
   localparam int REQ_MUL  = 2;
   localparam int REQ_CSR  = 3;

   // Index that follows idx in a ring of n slots.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin picker: starting at ptr, grants the first
// asserted request walking upward and wrapping. ptr is expected to be < N.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any_grant
);

   localparam int SW = IW + 1;

   logic [SW-1:0] slot;

   // Scan the ring from ptr and latch onto the first requester found.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      slot      = '0;
      for (int off = 0; off < N; off++) begin
         slot = {1'b0, ptr} + SW'(off);
         if (slot >= SW'(N)) begin
            slot = slot - SW'(N);
         end
         if (!any_grant && req[slot[IW-1:0]]) begin
            any_grant                = 1'b1;
            grant_idx                = slot[IW-1:0];
            grant[slot[IW-1:0]]      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file's single write port among the writeback
// requesters. Accepted writes go through one register stage; writes aimed at
// register 0 are accepted but only reported via zero_drop.
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                stall,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ-1:0][DEPTH-1:0]       req_addr,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
   output logic                                rf_we,
   output logic [DEPTH-1:0]                    rf_wr_addr,
   output logic [DATA_WIDTH-1:0]               rf_wr_data,
   output logic                                zero_drop,
   output logic                                busy
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]      rr_ptr;
   logic [NUM_REQ-1:0]    req_eligible;
   logic [NUM_REQ-1:0]    grant;
   logic [PTR_W-1:0]      grant_idx;
   logic                  any_grant;
   logic [DEPTH-1:0]      sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_is_zero;

   // Requests are masked while stalled or held in reset so no grant can leak
   // out; the mask depends only on valid/stall/reset, never on addr/data.
   assign req_eligible = (stall || !rst_n) ? '0 : req_valid;

   rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
      .req       (req_eligible),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   assign req_ready   = grant;
   assign sel_addr    = req_addr[grant_idx];
   assign sel_data    = req_data[grant_idx];
   assign sel_is_zero = (sel_addr == '0);
   assign busy        = (|req_valid) || rf_we;

   // Advance the round-robin pointer past whoever was just accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (any_grant) begin
         rr_ptr <= PTR_W'(wrap_inc(int'(grant_idx), NUM_REQ));
      end
   end

   // Register the accepted write toward the register file; reset discards a
   // write that has not yet been committed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we      <= 1'b0;
         rf_wr_addr <= '0;
         rf_wr_data <= '0;
         zero_drop  <= 1'b0;
      end else if (any_grant) begin
         rf_we      <= !sel_is_zero;
         zero_drop  <= sel_is_zero;
         rf_wr_addr <= sel_addr;
         rf_wr_data <= sel_data;
      end else begin
         rf_we      <= 1'b0;
         zero_drop  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scenario bench for regfile_wr_arbiter with a small round-robin model, a
// scoreboard queue of expected registered outputs and a register-file model.
module tb_regfile_wr_arbiter;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             stall;
   logic [3:0]       req_valid;
   logic [3:0]       req_ready;
   logic [3:0][1:0]  req_addr;
   logic [3:0][7:0]  req_data;
   logic             rf_we;
   logic [1:0]       rf_wr_addr;
   logic [7:0]       rf_wr_data;
   logic             zero_drop;
   logic             busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       we;
      logic       zd;
      logic [1:0] addr;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   int         m_ptr;
   logic [1:0] m_addr;
   logic [7:0] m_data;

   logic [7:0] rf_mem [4] = '{default: 8'h00};

   regfile_wr_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .rf_we      (rf_we),
      .rf_wr_addr (rf_wr_addr),
      .rf_wr_data (rf_wr_data),
      .zero_drop  (zero_drop),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Register file model: no reset, every write stored; a correct arbiter
   // never presents register 0 with rf_we high.
   always @(posedge clk) begin
      if (rf_we) rf_mem[rf_wr_addr] <= rf_wr_data;
   end

   function automatic int model_grant(input logic [3:0] v, input logic st, input int ptr);
      if (st || v == 4'b0000 || !rst_n) return -1;
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (ptr + k) % 4;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic void push_expect(input int g);
      exp_t e;
      if (g < 0) begin
         e.we = 1'b0;
         e.zd = 1'b0;
      end else begin
         m_addr = req_addr[g];
         m_data = req_data[g];
         e.we   = (req_addr[g] != 2'd0);
         e.zd   = (req_addr[g] == 2'd0);
         m_ptr  = (g + 1) % 4;
      end
      e.addr = m_addr;
      e.data = m_data;
      sb.push_back(e);
   endfunction

   function automatic void model_reset();
      m_ptr  = 0;
      m_addr = 2'd0;
      m_data = 8'h00;
      sb.delete();
   endfunction

   task automatic test_reset();
      rst_n     = 1'b0;
      stall     = 1'b0;
      req_valid = 4'b1111;
      req_addr  = '0;
      req_data  = '0;
      model_reset();
      #2;
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_ready: got %b want 0000", req_ready);
      end
      checks++;
      if ({rf_we, zero_drop, rf_wr_addr, rf_wr_data} !== 12'h000) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got we=%b zd=%b addr=%h data=%h want all zero",
                  rf_we, zero_drop, rf_wr_addr, rf_wr_data);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_busy: got %b want 1", busy);
      end
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if (req_ready !== 4'b0000 || rf_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_held: got ready=%b we=%b want 0000/0", req_ready, rf_we);
      end
      rst_n     = 1'b1;
      req_valid = 4'b0000;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_busy: got %b want 0", busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_write();
      logic [3:0] vt [2] = '{4'b0010, 4'b0000};
      logic [3:0] exp_ready;
      exp_t e;
      int   g;
      req_addr[1] = 2'd3;
      req_data[1] = 8'hA5;
      for (int c = 0; c < 2; c++) begin
         req_valid = vt[c];
         #1;
         g = model_grant(req_valid, stall, m_ptr);
         exp_ready = '0;
         if (g >= 0) exp_ready[g] = 1'b1;
         checks++;
         if (req_ready !== exp_ready) begin
            errors++;
            $display("[TB] FAIL single_ready[%0d]: got %b want %b", c, req_ready, exp_ready);
         end
         push_expect(g);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({rf_we, zero_drop, rf_wr_addr, rf_wr_data} !== {e.we, e.zd, e.addr, e.data}) begin
            errors++;
            $display("[TB] FAIL single_out[%0d]: got we=%b zd=%b addr=%h data=%h want we=%b zd=%b addr=%h data=%h",
                     c, rf_we, zero_drop, rf_wr_addr, rf_wr_data, e.we, e.zd, e.addr, e.data);
         end
      end
      checks++;
      if (rf_mem[3] !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL single_read: got reg3=%h want a5", rf_mem[3]);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_ready;
      int   seen [4] = '{0, 0, 0, 0};
      exp_t e;
      int   g;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_addr[i] = 2'(2 + (i & 1));
         req_data[i] = 8'(8'h10 * (i + 1));
      end
      req_valid = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         #1;
         g = model_grant(req_valid, stall, m_ptr);
         exp_ready = '0;
         if (g >= 0) exp_ready[g] = 1'b1;
         checks++;
         if (req_ready !== exp_ready) begin
            errors++;
            $display("[TB] FAIL rr_ready[%0d]: got %b want %b", c, req_ready, exp_ready);
         end
         for (int i = 0; i < 4; i++) if (req_ready[i]) seen[i]++;
         push_expect(g);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({rf_we, zero_drop, rf_wr_addr, rf_wr_data} !== {e.we, e.zd, e.addr, e.data}) begin
            errors++;
            $display("[TB] FAIL rr_out[%0d]: got we=%b zd=%b addr=%h data=%h want we=%b zd=%b addr=%h data=%h",
                     c, rf_we, zero_drop, rf_wr_addr, rf_wr_data, e.we, e.zd, e.addr, e.data);
         end
         if (g >= 0) req_data[g] = req_data[g] + 8'h01;
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (seen[i] < 1) begin
            errors++;
            $display("[TB] FAIL rr_starve[%0d]: got %0d grants want >=1", i, seen[i]);
         end
      end
      req_valid = 4'b0000;
   endtask

   task automatic test_zero_write();
      logic [3:0] vt [3] = '{4'b0100, 4'b0000, 4'b0000};
      logic [3:0] exp_ready;
      exp_t e;
      int   g;
      req_addr[2] = 2'd0;
      req_data[2] = 8'hFF;
      for (int c = 0; c < 3; c++) begin
         req_valid = vt[c];
         #1;
         g = model_grant(req_valid, stall, m_ptr);
         exp_ready = '0;
         if (g >= 0) exp_ready[g] = 1'b1;
         checks++;
         if (req_ready !== exp_ready) begin
            errors++;
            $display("[TB] FAIL zero_ready[%0d]: got %b want %b", c, req_ready, exp_ready);
         end
         push_expect(g);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({rf_we, zero_drop, rf_wr_addr, rf_wr_data} !== {e.we, e.zd, e.addr, e.data}) begin
            errors++;
            $display("[TB] FAIL zero_out[%0d]: got we=%b zd=%b addr=%h data=%h want we=%b zd=%b addr=%h data=%h",
                     c, rf_we, zero_drop, rf_wr_addr, rf_wr_data, e.we, e.zd, e.addr, e.data);
         end
      end
      checks++;
      if (rf_mem[0] !== 8'h00) begin
         errors++;
         $display("[TB] FAIL zero_read: got reg0=%h want 00", rf_mem[0]);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_stall();
      logic [3:0] vt [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
      logic       st [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [3:0] exp_ready;
      exp_t e;
      int   g;
      req_addr[0] = 2'd2;
      req_data[0] = 8'h77;
      for (int c = 0; c < 5; c++) begin
         req_valid = vt[c];
         stall     = st[c];
         #1;
         g = model_grant(req_valid, stall, m_ptr);
         exp_ready = '0;
         if (g >= 0) exp_ready[g] = 1'b1;
         checks++;
         if (req_ready !== exp_ready) begin
            errors++;
            $display("[TB] FAIL stall_ready[%0d]: got %b want %b", c, req_ready, exp_ready);
         end
         push_expect(g);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({rf_we, zero_drop, rf_wr_addr, rf_wr_data} !== {e.we, e.zd, e.addr, e.data}) begin
            errors++;
            $display("[TB] FAIL stall_out[%0d]: got we=%b zd=%b addr=%h data=%h want we=%b zd=%b addr=%h data=%h",
                     c, rf_we, zero_drop, rf_wr_addr, rf_wr_data, e.we, e.zd, e.addr, e.data);
         end
      end
      stall = 1'b0;
   endtask

   task automatic test_conflict();
      logic [3:0] vt [4] = '{4'b1000, 4'b0011, 4'b0010, 4'b0000};
      logic [3:0] exp_ready;
      exp_t e;
      int   g;
      req_addr[3] = 2'd3;
      req_data[3] = 8'h33;
      req_addr[0] = 2'd2;
      req_data[0] = 8'h11;
      req_addr[1] = 2'd2;
      req_data[1] = 8'h22;
      for (int c = 0; c < 4; c++) begin
         req_valid = vt[c];
         #1;
         g = model_grant(req_valid, stall, m_ptr);
         exp_ready = '0;
         if (g >= 0) exp_ready[g] = 1'b1;
         checks++;
         if (req_ready !== exp_ready) begin
            errors++;
            $display("[TB] FAIL conflict_ready[%0d]: got %b want %b", c, req_ready, exp_ready);
         end
         push_expect(g);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({rf_we, zero_drop, rf_wr_addr, rf_wr_data} !== {e.we, e.zd, e.addr, e.data}) begin
            errors++;
            $display("[TB] FAIL conflict_out[%0d]: got we=%b zd=%b addr=%h data=%h want we=%b zd=%b addr=%h data=%h",
                     c, rf_we, zero_drop, rf_wr_addr, rf_wr_data, e.we, e.zd, e.addr, e.data);
         end
         if (c == 2) begin
            checks++;
            if (rf_mem[2] !== 8'h11) begin
               errors++;
               $display("[TB] FAIL conflict_first: got reg2=%h want 11", rf_mem[2]);
            end
         end
      end
      checks++;
      if (rf_mem[2] !== 8'h22) begin
         errors++;
         $display("[TB] FAIL conflict_final: got reg2=%h want 22", rf_mem[2]);
      end
   endtask

   task automatic test_reset_mid_write();
      logic [3:0] exp_ready;
      exp_t e;
      int   g;
      req_addr[2] = 2'd1;
      req_data[2] = 8'h5C;
      req_valid   = 4'b0100;
      #1;
      g = model_grant(req_valid, stall, m_ptr);
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      checks++;
      if (req_ready !== exp_ready) begin
         errors++;
         $display("[TB] FAIL midrst_ready: got %b want %b", req_ready, exp_ready);
      end
      push_expect(g);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({rf_we, zero_drop, rf_wr_addr, rf_wr_data} !== {e.we, e.zd, e.addr, e.data}) begin
         errors++;
         $display("[TB] FAIL midrst_out: got we=%b zd=%b addr=%h data=%h want we=%b zd=%b addr=%h data=%h",
                  rf_we, zero_drop, rf_wr_addr, rf_wr_data, e.we, e.zd, e.addr, e.data);
      end
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      #1;
      checks++;
      if ({rf_we, zero_drop, rf_wr_addr, rf_wr_data} !== 12'h000) begin
         errors++;
         $display("[TB] FAIL midrst_clear: got we=%b zd=%b addr=%h data=%h want all zero",
                  rf_we, zero_drop, rf_wr_addr, rf_wr_data);
      end
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL midrst_ready_low: got %b want 0000", req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (rf_mem[1] !== 8'h00) begin
         errors++;
         $display("[TB] FAIL midrst_read: got reg1=%h want 00", rf_mem[1]);
      end
      rst_n = 1'b1;
      model_reset();
      #1;
      g = model_grant(req_valid, stall, m_ptr);
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      checks++;
      if (req_ready !== exp_ready) begin
         errors++;
         $display("[TB] FAIL midrst_regrant: got %b want %b", req_ready, exp_ready);
      end
      push_expect(g);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({rf_we, zero_drop, rf_wr_addr, rf_wr_data} !== {e.we, e.zd, e.addr, e.data}) begin
         errors++;
         $display("[TB] FAIL midrst_regrant_out: got we=%b zd=%b addr=%h data=%h want we=%b zd=%b addr=%h data=%h",
                  rf_we, zero_drop, rf_wr_addr, rf_wr_data, e.we, e.zd, e.addr, e.data);
      end
      req_valid = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_zero_write();
      test_stall();
      test_conflict();
      test_reset_mid_write();
      @(posedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port arbiter for the 2-read/1-write register file. It shares the single write port among NUM_REQ writeback requesters (ALU, load unit, multiplier, CSR path) using round-robin arbitration and a valid/ready handshake. Accepted writes pass through one registered stage that drives the register file's write-enable, address and data inputs. Writes to register 0 are accepted but never forwarded.

## Interface
- NUM_REQ, 4, number of writeback requesters (2..8)
- DATA_WIDTH, 8, register data width
- DEPTH, 2, address width; register file has 2**DEPTH locations
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  when high, no grant is issued this cycle
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_addr  in  NUM_REQ x DEPTH  per-requester destination register
- req_data  in  NUM_REQ x DATA_WIDTH  per-requester write data
- rf_we  out  1  register-file write enable
- rf_wr_addr  out  DEPTH  register-file write address
- rf_wr_data  out  DATA_WIDTH  register-file write data
- zero_drop  out  1  one-cycle pulse: accepted write targeted register 0 and was discarded
- busy  out  1  any req_valid high, or rf_we high

## Operation
- State: the round-robin pointer rr_ptr (clog2(NUM_REQ) bits), plus output registers rf_we, rf_wr_addr, rf_wr_data and zero_drop.
- Grant (combinational):
  - If stall=1 or no req_valid is high, req_ready = 0.
  - Otherwise grant the first valid requester at index rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready is set only for the granted index.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i] at a clock edge.
  - Requesters hold valid, addr and data stable until accepted.
  - A requester never withdraws valid before acceptance.
- On a transfer from requester g:
  - rr_ptr <= (g+1) mod NUM_REQ.
  - If req_addr[g] != 0: rf_we <= 1, rf_wr_addr <= req_addr[g], rf_wr_data <= req_data[g], zero_drop <= 0.
  - If req_addr[g] == 0: rf_we <= 0, zero_drop <= 1. The address and data registers take the request values, which are don't-care to the register file.
- No transfer: rf_we <= 0 and zero_drop <= 0. rr_ptr and the addr/data registers hold.
- Only one write reaches the register file per cycle. Two requesters targeting the same register are serialized in grant order, so the later grant wins.
- Reset values: rf_we=0, rf_wr_addr=0, rf_wr_data=0, zero_drop=0, rr_ptr=0. req_ready stays 0 while rst_n=0.
- Reset asserted mid-operation: the registered write not yet committed is discarded. The requester that was not yet accepted re-arbitrates from rr_ptr=0 after reset.

## Timing
- req_ready is combinational from req_valid, stall and rr_ptr. There is no combinational path from req_addr or req_data to req_ready.
- For a transfer at edge k:
  - rf_we is high during the cycle after edge k.
  - The register file captures the write at edge k+1.
  - Read ports return the new value in the cycle after edge k+1.
- Write latency from acceptance to committed storage: 2 edges.
- Sustained throughput: one write per cycle. Back-to-back transfers on consecutive edges produce rf_we high continuously.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 grants, provided stall is low.
- stall affects only new grants. A registered write already in flight still commits.

## Structure
- Shared package regfile_pkg:
  - default DATA_WIDTH and DEPTH
  - NUM_REQ default
  - requester index constants (REQ_ALU=0, REQ_LOAD=1, REQ_MUL=2, REQ_CSR=3)
- Sub-module rr_arbiter:
  - inputs: request vector, pointer
  - outputs: one-hot grant, grant index, any_grant
  - purely combinational and reusable
  - rr_ptr update stays in regfile_wr_arbiter.

## Test plan
- Reset, then single write: req_valid=0010, req_addr[1]=3, req_data[1]=0xA5 → req_ready=0010 same cycle; next cycle rf_we=1, rf_wr_addr=3, rf_wr_data=0xA5; register 3 reads 0xA5 one cycle later.
- All four valid continuously with distinct data from reset → grants in order 0,1,2,3,0; rf_we high on every cycle; no requester starves.
- Register-0 write: requester 2 writes addr 0, data 0xFF → accepted; rf_we stays 0; zero_drop pulses for one cycle; register 0 still reads 0x00.
- Stall: requester 0 valid with stall=1 for 3 cycles → req_ready=0 throughout, rf_we=0; grant in the first cycle stall=0.
- Same-address conflict: requester 0 writes reg 2 = 0x11 and requester 1 writes reg 2 = 0x22, both valid with rr_ptr=0 → 0x11 is written first, then 0x22; final read of reg 2 is 0x22.
- Reset mid-write: assert rst_n=0 in the cycle rf_we=1 for addr 1, data 0x5C → rf_we drops to 0 immediately; register 1 reads 0x00; after release the next grant starts at requester 0.
